adc_channel_averager: RTL and testbench

- Parametrised successor to the single-sequencer ADC CSR wrapper.
- Accepts the raw per-channel sample stream from the ADC core and accumulates 2^avgLog2 samples per channel. Pushes each truncated average, tagged with its channel, into a FIFO read over a CSR port.
- Level-threshold IRQ to the CPU interrupt controller.
- Sits between the ADC core sample output and the system bus. The CSR port has the same 2-cycle read latency and valid-pulse convention as the other ADC CSR ports.

---
 rtl/adc_channel_averager.sv | 221 ++++++++++++++++++++++
 tb/tb_adc_channel_averager.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_channel_averager.sv
// Per-channel 2^avgLog2 ADC sample averager with a CSR-popped result FIFO and a level IRQ; optional ADC_AVG_TIMESTAMP_EN stamps results.
// CSR reads return data 2 cycles after the strobe; a result that meets a full FIFO is dropped and flagged sticky.

module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (level == DEPTH_L);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop_ok);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
endmodule

module adc_channel_averager #(
  parameter int CHANNELS     = 8,
  parameter int DATA_WIDTH   = 12,
  parameter int AVG_LOG2_MAX = 6,
  parameter int FIFO_DEPTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sampleInValid,
  input  logic [3:0]            sampleInChannel,
  input  logic [DATA_WIDTH-1:0] sampleInData,
  input  logic [1:0]            csrAddress,
  input  logic                  csrRead,
  input  logic                  csrWrite,
  input  logic [31:0]           csrDataIn,
  output logic [31:0]           csrDataOut,
  output logic                  csrValid,
  output logic                  irq
);
  localparam int ACC_W = DATA_WIDTH + AVG_LOG2_MAX;
  localparam int CNT_W = (AVG_LOG2_MAX > 0) ? AVG_LOG2_MAX : 1;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] AVG_MAX = 3'(AVG_LOG2_MAX);
  localparam logic [4:0] CH_LIM  = 5'(CHANNELS);
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_FIFO   = 2'd2;
  localparam logic [1:0] ADDR_THR    = 2'd3;

  logic             enable;
  logic             irq_en;
  logic [2:0]       avg_log2;
  logic [7:0]       threshold;
  logic             overflow;
  logic [ACC_W-1:0] acc [CHANNELS];
  logic [CNT_W-1:0] cnt [CHANNELS];

  logic             ctrl_wr;
  logic             thr_wr;
  logic             flush;
  logic             fifo_rd;
  logic [2:0]       avg_wr;
  logic             clear_acc;
  logic             acc_active;
  logic             acc_done;
  logic [CH_W-1:0]  ch;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] acc_shift;
  logic [CNT_W-1:0] cnt_last;
  logic [11:0]      ts;
  logic [31:0]      push_word;
  logic             fifo_push;
  logic             drop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [31:0]      fifo_dat;
  logic [LVL_W-1:0] fifo_level;
  logic [31:0]      rd_mux;
  logic [31:0]      rd_dat_s1;
  logic             rd_vld_s1;
  logic             unused_bits;

  assign ctrl_wr   = csrWrite && (csrAddress == ADDR_CTRL);
  assign thr_wr    = csrWrite && (csrAddress == ADDR_THR);
  assign flush     = ctrl_wr && csrDataIn[5];
  assign fifo_rd   = csrRead && (csrAddress == ADDR_FIFO);
  assign avg_wr    = (csrDataIn[3:1] > AVG_MAX) ? AVG_MAX : csrDataIn[3:1];
  // Disabling or re-scaling restarts every channel so no average mixes two settings.
  assign clear_acc = ctrl_wr && (!csrDataIn[0] || (avg_wr != avg_log2));

  assign ch         = sampleInChannel[CH_W-1:0];
  assign acc_active = enable && sampleInValid && ({1'b0, sampleInChannel} < CH_LIM);
  assign acc_sum    = acc[ch] + ACC_W'(sampleInData);
  assign acc_shift  = acc_sum >> avg_log2;
  assign cnt_last   = CNT_W'((1 << avg_log2) - 1);
  assign acc_done   = (cnt[ch] == cnt_last);
  assign fifo_push  = acc_active && acc_done && !clear_acc;
  assign drop       = fifo_push && fifo_full && !fifo_rd;
  assign push_word  = {sampleInChannel, ts, 16'(acc_shift[DATA_WIDTH-1:0])};

`ifdef ADC_AVG_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (reset || flush) ts <= '0;
    else                ts <= ts + 12'd1;
  end
`else
  assign ts = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset || clear_acc) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (acc_active) begin
      if (acc_done) begin
        acc[ch] <= '0;
        cnt[ch] <= '0;
      end else begin
        acc[ch] <= acc_sum;
        cnt[ch] <= cnt[ch] + CNT_W'(1);
      end
    end
  end

  fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push     (fifo_push),
    .push_dat (push_word),
    .pop      (fifo_rd),
    .pop_dat  (fifo_dat),
    .level    (fifo_level),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      enable    <= 1'b0;
      avg_log2  <= '0;
      irq_en    <= 1'b0;
      threshold <= '0;
      overflow  <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        enable   <= csrDataIn[0];
        avg_log2 <= avg_wr;
        irq_en   <= csrDataIn[4];
      end
      if (thr_wr) threshold <= csrDataIn[7:0];
      if (flush)     overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (csrAddress)
      ADDR_CTRL:   rd_mux = {26'd0, 1'b0, irq_en, avg_log2, enable};
      ADDR_STATUS: rd_mux = {21'd0, overflow, fifo_full, fifo_empty, 8'(fifo_level)};
      ADDR_FIFO:   rd_mux = fifo_empty ? 32'd0 : fifo_dat;
      default:     rd_mux = {24'd0, threshold};
    endcase
  end

  // Stage 1 captures the pre-write view at the strobe edge; stage 2 presents it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_s1  <= 1'b0;
      rd_dat_s1  <= '0;
      csrValid   <= 1'b0;
      csrDataOut <= '0;
      irq        <= 1'b0;
    end else begin
      rd_vld_s1 <= csrRead;
      if (csrRead) rd_dat_s1 <= rd_mux;
      csrValid <= rd_vld_s1;
      if (rd_vld_s1) csrDataOut <= rd_dat_s1;
      irq <= irq_en && (threshold != 8'd0) && (16'(fifo_level) >= 16'(threshold));
    end
  end

  assign unused_bits = ^{csrDataIn[31:8], acc_shift[ACC_W-1:DATA_WIDTH]};
endmodule

// File: tb/tb_adc_channel_averager.sv
// Bench for adc_channel_averager: directed literal checks plus random traffic against a queue-based reference model.
module tb_adc_channel_averager;
  localparam int CHANNELS     = 8;
  localparam int DATA_WIDTH   = 12;
  localparam int AVG_LOG2_MAX = 6;
  localparam int FIFO_DEPTH   = 32;
`ifdef ADC_AVG_TIMESTAMP_EN
  localparam logic [31:0] LIT_MASK = 32'hF000_FFFF;
`else
  localparam logic [31:0] LIT_MASK = 32'hFFFF_FFFF;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  sampleInValid = 1'b0;
  logic [3:0]            sampleInChannel = '0;
  logic [DATA_WIDTH-1:0] sampleInData = '0;
  logic [1:0]            csrAddress = '0;
  logic                  csrRead = 1'b0;
  logic                  csrWrite = 1'b0;
  logic [31:0]           csrDataIn = '0;
  logic [31:0]           csrDataOut;
  logic                  csrValid;
  logic                  irq;

  int n_cmp = 0;
  int n_bad = 0;

  adc_channel_averager #(
    .CHANNELS(CHANNELS), .DATA_WIDTH(DATA_WIDTH),
    .AVG_LOG2_MAX(AVG_LOG2_MAX), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .sampleInValid(sampleInValid), .sampleInChannel(sampleInChannel), .sampleInData(sampleInData),
    .csrAddress(csrAddress), .csrRead(csrRead), .csrWrite(csrWrite), .csrDataIn(csrDataIn),
    .csrDataOut(csrDataOut), .csrValid(csrValid), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          chq [16][$];
  logic [31:0] fq[$];
  bit          m_en, m_irqen, m_ovf;
  int          m_avg, m_thr, m_ts;
  bit          s1_v, e_v, e_irq, started;
  logic [31:0] s1_d, e_d;

  task automatic model_step();
    logic [31:0] rd;
    int lvl, sat, sum, n;
    bit clr;
    if (reset) begin
      for (int c = 0; c < 16; c++) chq[c].delete();
      fq.delete();
      m_en = 0; m_irqen = 0; m_ovf = 0; m_avg = 0; m_thr = 0; m_ts = 0;
      s1_v = 0; s1_d = '0; e_v = 0; e_d = '0; e_irq = 0;
      started = 1;
      return;
    end
    lvl = fq.size();
    case (csrAddress)
      2'd0:    rd = {26'd0, 1'b0, m_irqen, 3'(m_avg), m_en};
      2'd1:    rd = {21'd0, m_ovf, lvl == FIFO_DEPTH, lvl == 0, 8'(lvl)};
      2'd2:    rd = (lvl > 0) ? fq[0] : 32'd0;
      default: rd = {24'd0, 8'(m_thr)};
    endcase
    if (s1_v) e_d = s1_d;
    e_v = s1_v;
    s1_v = csrRead;
    s1_d = rd;
    e_irq = m_irqen && (m_thr != 0) && (lvl >= m_thr);
    if (csrRead && csrAddress == 2'd2 && lvl > 0) void'(fq.pop_front());
    sat = int'(csrDataIn[3:1]);
    if (sat > AVG_LOG2_MAX) sat = AVG_LOG2_MAX;
    clr = csrWrite && csrAddress == 2'd0 && (!csrDataIn[0] || sat != m_avg);
    if (!clr && m_en && sampleInValid && sampleInChannel < CHANNELS) begin
      chq[sampleInChannel].push_back(int'(sampleInData));
      n = chq[sampleInChannel].size();
      if (n == (1 << m_avg)) begin
        sum = 0;
        for (int k = 0; k < n; k++) sum += chq[sampleInChannel][k];
`ifdef ADC_AVG_TIMESTAMP_EN
        if (fq.size() < FIFO_DEPTH) fq.push_back({sampleInChannel, 12'(m_ts), 16'(sum / n)});
`else
        if (fq.size() < FIFO_DEPTH) fq.push_back({sampleInChannel, 12'd0, 16'(sum / n)});
`endif
        else m_ovf = 1;
        chq[sampleInChannel].delete();
      end
    end
    if (clr) for (int c = 0; c < 16; c++) chq[c].delete();
    m_ts = (m_ts + 1) % 4096;
    if (csrWrite && csrAddress == 2'd0) begin
      m_en = csrDataIn[0];
      m_avg = sat;
      m_irqen = csrDataIn[4];
      if (csrDataIn[5]) begin
        fq.delete();
        m_ovf = 0;
        m_ts = 0;
      end
    end
    if (csrWrite && csrAddress == 2'd3) m_thr = int'(csrDataIn[7:0]);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      check("csrValid", {31'd0, csrValid}, {31'd0, e_v});
      check("csrDataOut", csrDataOut, e_d);
      check("irq", {31'd0, irq}, {31'd0, e_irq});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    csrWrite = 1; csrAddress = a; csrDataIn = d;
    tick();
    csrWrite = 0;
  endtask

  task automatic sample(input logic [3:0] c, input int v);
    sampleInValid = 1; sampleInChannel = c; sampleInData = DATA_WIDTH'(v);
    tick();
    sampleInValid = 0;
  endtask

  task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp,
                          input logic [31:0] mask);
    csrRead = 1; csrAddress = a;
    tick();
    csrRead = 0;
    tick();
    check({name, "_vld"}, {31'd0, csrValid}, 32'd1);
    check(name, csrDataOut & mask, exp);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_valid", {31'd0, csrValid}, 32'd0);
    check("rst_dout", csrDataOut, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset = 0;
    read_chk("rst_ctrl", 2'd0, 32'h0, '1);
    read_chk("rst_status", 2'd1, 32'h100, '1);

    // average of 100..107 on ch2
    csr_write(2'd0, 32'h07);
    for (int i = 0; i < 8; i++) sample(4'd2, 100 + i);
    read_chk("t1_status", 2'd1, 32'h001, '1);
    read_chk("t1_pop", 2'd2, 32'h2000_0067, LIT_MASK);
    read_chk("t1_status_after", 2'd1, 32'h100, '1);

    // 33 pass-through results into a 32-deep FIFO
    csr_write(2'd0, 32'h01);
    for (int i = 0; i < 33; i++) sample(4'd0, i);
    read_chk("t2_status_full", 2'd1, 32'h620, '1);
    for (int i = 0; i < 32; i++) read_chk("t2_pop", 2'd2, {16'd0, 16'(i)}, LIT_MASK);
    read_chk("t2_status_drained", 2'd1, 32'h500, '1);
    csr_write(2'd0, 32'h21);
    read_chk("t2_status_flushed", 2'd1, 32'h100, '1);

    // threshold IRQ
    csr_write(2'd3, 32'd4);
    csr_write(2'd0, 32'h11);
    for (int i = 1; i <= 4; i++) sample(4'd3, i);
    check("t3_irq_lag", {31'd0, irq}, 32'd0);
    tick();
    check("t3_irq_rise", {31'd0, irq}, 32'd1);
    read_chk("t3_pop", 2'd2, 32'h3000_0001, LIT_MASK);
    check("t3_irq_fall", {31'd0, irq}, 32'd0);
    csr_write(2'd0, 32'h21);

    // empty pop, then three back-to-back pops
    read_chk("t4_empty_pop", 2'd2, 32'h0, '1);
    read_chk("t4_status", 2'd1, 32'h100, '1);
    sample(4'd5, 7); sample(4'd5, 8); sample(4'd5, 9);
    csrRead = 1; csrAddress = 2'd2;
    tick(); tick();
    check("t4_b2b0_vld", {31'd0, csrValid}, 32'd1);
    check("t4_b2b0", csrDataOut & LIT_MASK, 32'h5000_0007);
    tick();
    csrRead = 0;
    check("t4_b2b1_vld", {31'd0, csrValid}, 32'd1);
    check("t4_b2b1", csrDataOut & LIT_MASK, 32'h5000_0008);
    tick();
    check("t4_b2b2_vld", {31'd0, csrValid}, 32'd1);
    check("t4_b2b2", csrDataOut & LIT_MASK, 32'h5000_0009);
    tick();
    check("t4_b2b_end", {31'd0, csrValid}, 32'd0);

    // avgLog2 saturation
    csr_write(2'd0, 32'h0F);
    read_chk("sat_ctrl", 2'd0, 32'h0D, '1);

    // reset mid-average
    csr_write(2'd0, 32'h03);
    sample(4'd0, 5);
    sample(4'd1, 3);
    reset = 1;
    tick();
    reset = 0;
    read_chk("t5_status", 2'd1, 32'h100, '1);
    read_chk("t5_ctrl", 2'd0, 32'h0, '1);
    csr_write(2'd0, 32'h03);
    sample(4'd1, 10);
    sample(4'd1, 11);
    read_chk("t5_pop", 2'd2, 32'h1000_000A, LIT_MASK);

`ifdef ADC_AVG_TIMESTAMP_EN
    csr_write(2'd0, 32'h21);
    sample(4'd1, 1);
    repeat (4) tick();
    sample(4'd1, 2);
    read_chk("t6_ts0", 2'd2, 32'h1000_0001, '1);
    read_chk("t6_ts5", 2'd2, 32'h1005_0002, '1);
    read_chk("t6_status", 2'd1, 32'h100, '1);
`endif

    // randomized traffic
    csr_write(2'd3, 32'd6);
    csr_write(2'd0, 32'h11);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      reset           = ($urandom_range(599) == 0);
      sampleInValid   = ($urandom_range(3) != 0);
      sampleInChannel = 4'($urandom_range(15));
      sampleInData    = DATA_WIDTH'($urandom);
      csrRead         = ($urandom_range(2) == 0);
      csrWrite        = ($urandom_range(11) == 0);
      csrAddress      = 2'($urandom_range(3));
      case (csrAddress)
        2'd0: csrDataIn = {26'd0, 1'($urandom_range(9) == 0), 1'($urandom_range(1)),
                           3'($urandom_range(7)), 1'($urandom_range(7) != 0)};
        2'd3: csrDataIn = 32'($urandom_range(40));
        default: csrDataIn = $urandom;
      endcase
      tick();
    end
    reset = 0; sampleInValid = 0; csrRead = 0; csrWrite = 0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
